// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor that processes DIGIT bits per clock through a
// registered carry. It replaces wide ripple adders where area matters more
// than latency.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   DIGIT  bits added per cycle; must divide WIDTH (STEPS = WIDTH/DIGIT)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode are valid
//   in_ready   block can accept an operation (IDLE)
//   in_a/in_b  operands
//   in_cin     carry-in for add; ignored when in_sub=1
//   in_sub     0: A+B+cin, 1: A-B
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   carry      carry out of the MSB; for subtract 1 = no borrow
//   overflow   two's-complement signed overflow
//
// Latency: an accept on edge N gives out_valid from cycle N+STEPS. Results stay
// stable through the handshake and until the next completion.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]       a_sh, b_sh, res_sh;
  logic                   cy;
  logic [CW-1:0]          cnt;
  logic                   last;

  logic [DIGIT:0]         dsum;
  logic [DIGIT-1:0]       d;
  logic                   c_next;
  logic                   c_msb;
  logic [WIDTH+DIGIT-1:0] res_cat;

  // One digit of ripple addition on the low end of the shift registers.
  always_comb begin
    dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, cy};
    d       = dsum[DIGIT-1:0];
    c_next  = dsum[DIGIT];
    // The sum bit is a^b^cin, so cin can be recovered from the top bit of the
    // digit. During the final step that bit is the MSB of the word.
    c_msb   = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ d[DIGIT-1];
    // The new digit enters at the top. The top WIDTH bits are the shifted
    // result. This also covers DIGIT == WIDTH without a zero-width slice.
    res_cat = {d, res_sh};
  end

  assign last      = (cnt == CW'(STEPS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: state registers use non-blocking assignments so that every register
  // samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case. Any path that does not
  // assign it keeps the current state, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last)      state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // NOTE: the shift registers, the counter and the carry are all reset. An
  // operation aborted by reset then leaves no stale digits, and the outputs
  // are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1, done on the same adder.
            a_sh <= in_a;
            b_sh <= in_sub ? ~in_b : in_b;
            cy   <= in_sub ? 1'b1 : in_cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_cat[WIDTH+DIGIT-1:DIGIT];
          cy     <= c_next;
          if (last) begin
            sum      <= res_cat[WIDTH+DIGIT-1:DIGIT];
            carry    <= c_next;
            overflow <= c_msb ^ c_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;  // DONE: hold results until the next completion
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Drives three serial_adder instances (WIDTH=8; DIGIT=1, 2 and 8) with shared
// stimulus and checks each instance against hand-computed vectors and against a
// behavioural model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int N = 3;
  localparam int DIGS    [N] = '{1, 2, 8};
  localparam int STEPS_E [N] = '{8, 4, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       in_sub = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_o  [N];
  logic       out_valid_o [N];
  logic [7:0] sum_o       [N];
  logic       carry_o     [N];
  logic       ov_o        [N];

  int total = 0;
  int bad   = 0;

  // Results captured by run_op at the first cycle out_valid was seen.
  logic [7:0] r_sum   [N];
  logic       r_carry [N];
  logic       r_ov    [N];
  int         r_lat   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(DIGS[g])) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_o[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid_o[g]),
      .out_ready (out_ready),
      .sum       (sum_o[g]),
      .carry     (carry_o[g]),
      .overflow  (ov_o[g])
    );
  end

  // Behavioural reference: {carry, overflow, sum}.
  function automatic logic [9:0] model(input logic [7:0] a, b,
                                       input logic cin, sub);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
    ov   = (a[7] == bb[7]) && (full[7] != a[7]);
    return {full[8], ov, full[7:0]};
  endfunction

  // Issue one operation and capture each instance's result and latency.
  // If release_out is set, a one-cycle out_ready handshake follows.
  task automatic run_op(input logic [7:0] a, b, input logic cin, sub,
                        input bit release_out);
    bit all_seen;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) r_lat[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (r_lat[i] == 0) begin
          if (out_valid_o[i]) begin
            r_lat[i]   = k;
            r_sum[i]   = sum_o[i];
            r_carry[i] = carry_o[i];
            r_ov[i]    = ov_o[i];
          end else begin
            all_seen = 1'b0;
          end
        end
      end
      if (all_seen) break;
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < N; i++) begin
      total++;
      if (out_valid_o[i] !== 1'b0 || sum_o[i] !== 8'h00 ||
          carry_o[i] !== 1'b0 || ov_o[i] !== 1'b0 || in_ready_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset d%0d: valid=%b sum=%h c=%b ov=%b rdy=%b want 0 00 0 0 1",
                 DIGS[i], out_valid_o[i], sum_o[i], carry_o[i], ov_o[i], in_ready_o[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [7:0] va [4] = '{8'h5A, 8'hFF, 8'h7F, 8'h01};
    logic [7:0] vb [4] = '{8'h3C, 8'h01, 8'h00, 8'h02};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [4] = '{8'h96, 8'h00, 8'h80, 8'h03};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      run_op(va[v], vb[v], vc[v], 1'b0, 1'b1);
      for (int i = 0; i < N; i++) begin
        total++;
        if ({r_carry[i], r_ov[i], r_sum[i]} !== {ec[v], eo[v], es[v]}) begin
          bad++;
          $display("FAIL add%0d d%0d: got c=%b ov=%b sum=%h want c=%b ov=%b sum=%h",
                   v, DIGS[i], r_carry[i], r_ov[i], r_sum[i], ec[v], eo[v], es[v]);
        end
        total++;
        if (r_lat[i] !== STEPS_E[i]) begin
          bad++;
          $display("FAIL add_latency%0d d%0d: got %0d want %0d",
                   v, DIGS[i], r_lat[i], STEPS_E[i]);
        end
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va [3] = '{8'h10, 8'h80, 8'h10};
    logic [7:0] vb [3] = '{8'h20, 8'h01, 8'h20};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'hF0, 8'h7F, 8'hF0};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      run_op(va[v], vb[v], vc[v], 1'b1, 1'b1);
      for (int i = 0; i < N; i++) begin
        total++;
        if ({r_carry[i], r_ov[i], r_sum[i]} !== {ec[v], eo[v], es[v]}) begin
          bad++;
          $display("FAIL sub%0d d%0d: got c=%b ov=%b sum=%h want c=%b ov=%b sum=%h",
                   v, DIGS[i], r_carry[i], r_ov[i], r_sum[i], ec[v], eo[v], es[v]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      // This request arrives while the block is busy and must be ignored.
      in_a = 8'h11; in_b = 8'h22; in_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        total++;
        if (out_valid_o[i] !== 1'b1 || in_ready_o[i] !== 1'b0 ||
            sum_o[i] !== 8'h96 || carry_o[i] !== 1'b0 || ov_o[i] !== 1'b1) begin
          bad++;
          $display("FAIL hold%0d d%0d: valid=%b rdy=%b sum=%h c=%b ov=%b want 1 0 96 0 1",
                   c, DIGS[i], out_valid_o[i], in_ready_o[i], sum_o[i], carry_o[i], ov_o[i]);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    for (int i = 0; i < N; i++) begin
      total++;
      if (in_ready_o[i] !== 1'b1 || out_valid_o[i] !== 1'b0 || sum_o[i] !== 8'h96) begin
        bad++;
        $display("FAIL release d%0d: rdy=%b valid=%b sum=%h want 1 0 96",
                 DIGS[i], in_ready_o[i], out_valid_o[i], sum_o[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid [N];
    in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if (out_valid_o[i] !== 1'b0 || sum_o[i] !== 8'h00 ||
          carry_o[i] !== 1'b0 || ov_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset d%0d: valid=%b sum=%h c=%b ov=%b want 0 00 0 0",
                 DIGS[i], out_valid_o[i], sum_o[i], carry_o[i], ov_o[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) saw_valid[i] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (out_valid_o[i] !== 1'b0) saw_valid[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (saw_valid[i] || in_ready_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL post_reset d%0d: saw_valid=%b rdy=%b want 0 1",
                 DIGS[i], saw_valid[i], in_ready_o[i]);
      end
    end
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if ({r_carry[i], r_ov[i], r_sum[i]} !== {1'b0, 1'b0, 8'h03} ||
          r_lat[i] !== STEPS_E[i]) begin
        bad++;
        $display("FAIL clean_op d%0d: c=%b ov=%b sum=%h lat=%0d want 0 0 03 lat=%0d",
                 DIGS[i], r_carry[i], r_ov[i], r_sum[i], r_lat[i], STEPS_E[i]);
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [7:0] a, b;
    logic       cin, sub;
    logic [9:0] exp_v;
    for (int n = 0; n < 200; n++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      exp_v = model(a, b, cin, sub);
      run_op(a, b, cin, sub, 1'b1);
      for (int i = 0; i < N; i++) begin
        total++;
        if ({r_carry[i], r_ov[i], r_sum[i]} !== exp_v || r_lat[i] !== STEPS_E[i]) begin
          bad++;
          $display("FAIL rand%0d d%0d: %h %s %h cin=%b got c=%b ov=%b sum=%h lat=%0d want c=%b ov=%b sum=%h lat=%0d",
                   n, DIGS[i], a, (sub ? "-" : "+"), b, cin, r_carry[i], r_ov[i],
                   r_sum[i], r_lat[i], exp_v[9], exp_v[8], exp_v[7:0], STEPS_E[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
